// File: rtl/bp_be_fe_adapter_pkg.sv
// bp_be_fe_adapter_pkg
//   Shared types for the FE-BE adapter slice: FE queue packet and FE command
//   layouts, their opcode / message enums, and the adapter state enum.
//   The opcode sits in the top bits of a command and msg_type in the top bits
//   of a queue packet, so either can be sliced straight off a flat vector.
package bp_be_fe_adapter_pkg;

  localparam int vaddr_width_gp   = 39;
  localparam int instr_width_gp   = 32;
  localparam int operand_width_gp = 32;

  typedef enum logic [1:0] {
    e_fe_fetch     = 2'd0,
    e_fe_exception = 2'd1
  } bp_fe_queue_type_e;

  typedef enum logic [3:0] {
    e_instr_misaligned   = 4'd0,
    e_instr_access_fault = 4'd1,
    e_illegal_instr      = 4'd2,
    e_itlb_miss          = 4'd3,
    e_instr_page_fault   = 4'd4,
    e_icache_miss        = 4'd5
  } bp_fe_exception_code_e;

  typedef enum logic [2:0] {
    e_op_state_reset          = 3'd0,
    e_op_pc_redirection       = 3'd1,
    e_op_interrupt            = 3'd2,
    e_op_icache_fill_response = 3'd3,
    e_op_icache_fence         = 3'd4,
    e_op_attaboy              = 3'd5,
    e_op_itlb_fill_response   = 3'd6,
    e_op_itlb_fence           = 3'd7
  } bp_fe_command_queue_opcodes_e;

  typedef struct packed {
    bp_fe_queue_type_e             msg_type;
    bp_fe_exception_code_e         exc_code;
    logic [vaddr_width_gp-1:0]     vaddr;
    logic [instr_width_gp-1:0]     instr;
  } bp_fe_queue_s;

  typedef struct packed {
    bp_fe_command_queue_opcodes_e  opcode;
    logic [vaddr_width_gp-1:0]     vaddr;
    logic [operand_width_gp-1:0]   operand;
  } bp_fe_cmd_s;

  localparam int fe_queue_width_gp = $bits(bp_fe_queue_s);
  localparam int fe_cmd_width_gp   = $bits(bp_fe_cmd_s);
  localparam int cmd_op_width_gp   = $bits(bp_fe_command_queue_opcodes_e);
  localparam int msg_type_width_gp = $bits(bp_fe_queue_type_e);

  typedef enum logic {
    e_run    = 1'b0,
    e_parked = 1'b1
  } bp_be_adapter_state_e;

endpackage

// File: rtl/bp_be_fe_adapter_fifo.sv
// bp_be_fe_queue_fifo
//   1-read 1-write flushable FIFO. Head is registered storage (no bypass),
//   so an entry written this cycle is visible at data_o next cycle.
//   Ports:
//     clk_i, reset_i  clock, synchronous active-high reset (pointers only)
//     clear_i         empty the FIFO next cycle; overrides enqueue/dequeue
//     data_i, v_i     write side; written when v_i & ready_o
//     ready_o         not full (no pass-through when full)
//     data_o, v_o     head entry and its valid
//     yumi_i          consume head; ignored when empty
module bp_be_fe_queue_fifo
  import bp_be_fe_adapter_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = $clog2(els_p);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [ptr_w_lp:0] wptr_q, wptr_d;
  logic [ptr_w_lp:0] rptr_q, rptr_d;
  logic [width_p-1:0] mem_q [els_p];
  logic full, empty, enq, deq;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp])
                && (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);
  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_q[rptr_q[ptr_w_lp-1:0]];
  assign enq     = v_i & ~full;
  assign deq     = yumi_i & ~empty;

  always_comb begin
    wptr_d = wptr_q + (ptr_w_lp+1)'(enq);
    rptr_d = rptr_q + (ptr_w_lp+1)'(deq);
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q[ptr_w_lp-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/bp_be_fe_adapter.sv
// bp_be_fe_adapter
//   Back-end endpoint of the FE-BE interface. Buffers FE queue packets for
//   the issue stage and serializes BE-built commands onto the fe_cmd channel.
//   Once a non-attaboy command is enqueued, every FE packet that arrives
//   before the FE consumes that command is stale and is discarded.
//   Ports:
//     clk_i, reset_i                      clock, sync active-high reset
//     fe_queue_i/_v_i, fe_queue_ready_o   packet stream from the FE
//     issue_pkt_o/_v_o, issue_pkt_yumi_i  buffered packets to issue
//     cmd_i/_v_i, cmd_ready_o             commands from the BE
//     fe_cmd_o/_v_o, fe_cmd_yumi_i        commands to the FE
//     fe_stalled_o                        FE parked after an exception
//     redirect_pending_o                  non-attaboy commands in flight
module bp_be_fe_adapter
  import bp_be_fe_adapter_pkg::*;
#(
  parameter int fe_queue_els_p = 8,
  parameter int fe_cmd_els_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,

  input  logic [fe_queue_width_gp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,

  output logic [fe_queue_width_gp-1:0] issue_pkt_o,
  output logic                         issue_pkt_v_o,
  input  logic                         issue_pkt_yumi_i,

  input  logic [fe_cmd_width_gp-1:0]   cmd_i,
  input  logic                         cmd_v_i,
  output logic                         cmd_ready_o,

  output logic [fe_cmd_width_gp-1:0]   fe_cmd_o,
  output logic                         fe_cmd_v_o,
  input  logic                         fe_cmd_yumi_i,

  output logic                         fe_stalled_o,
  output logic                         redirect_pending_o
);

  localparam int pend_w_lp = $clog2(fe_cmd_els_p+1);

  logic [cmd_op_width_gp-1:0]   cmd_op_li, fe_cmd_op_lo;
  logic [msg_type_width_gp-1:0] fe_queue_msg_li;
  logic cmd_fifo_ready, cmd_fifo_v;
  logic fq_fifo_ready, fq_fifo_v;
  logic cmd_nonattaboy_enq, cmd_nonattaboy_deq;
  logic drop, fq_accept, exc_accept;

  logic [pend_w_lp-1:0] pending_q, pending_d;
  bp_be_adapter_state_e state_q;

  assign cmd_op_li       = cmd_i[fe_cmd_width_gp-1 -: cmd_op_width_gp];
  assign fe_cmd_op_lo    = fe_cmd_o[fe_cmd_width_gp-1 -: cmd_op_width_gp];
  assign fe_queue_msg_li = fe_queue_i[fe_queue_width_gp-1 -: msg_type_width_gp];

  // Command path
  bp_be_fe_queue_fifo #(
    .width_p(fe_cmd_width_gp),
    .els_p  (fe_cmd_els_p)
  ) cmd_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(1'b0),
    .data_i (cmd_i),
    .v_i    (cmd_v_i),
    .ready_o(cmd_fifo_ready),
    .data_o (fe_cmd_o),
    .v_o    (cmd_fifo_v),
    .yumi_i (fe_cmd_yumi_i)
  );

  assign cmd_nonattaboy_enq = cmd_v_i & cmd_fifo_ready
                            & (cmd_op_li != e_op_attaboy);
  assign cmd_nonattaboy_deq = fe_cmd_yumi_i & cmd_fifo_v
                            & (fe_cmd_op_lo != e_op_attaboy);

  // Counts non-attaboy commands the FE has not consumed yet. Bounded by the
  // command FIFO depth, so it cannot overflow.
  always_comb begin
    pending_d = pending_q;
    case ({cmd_nonattaboy_enq, cmd_nonattaboy_deq})
      2'b10:   pending_d = pending_q + pend_w_lp'(1);
      2'b01:   pending_d = pending_q - pend_w_lp'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  // FE queue path: while a redirect is outstanding, every handshaken packet
  // is stale, so it is accepted and thrown away rather than stored.
  assign drop      = cmd_nonattaboy_enq | (pending_q != '0);
  assign fq_accept = fe_queue_v_i & ~drop;

  bp_be_fe_queue_fifo #(
    .width_p(fe_queue_width_gp),
    .els_p  (fe_queue_els_p)
  ) fq_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(cmd_nonattaboy_enq),
    .data_i (fe_queue_i),
    .v_i    (fq_accept),
    .ready_o(fq_fifo_ready),
    .data_o (issue_pkt_o),
    .v_o    (fq_fifo_v),
    .yumi_i (issue_pkt_yumi_i)
  );

  // Exception tracking. A stored exception packet parks the FE until it
  // consumes a non-attaboy command. Both events cannot coincide: a
  // non-attaboy dequeue implies pending_q != 0, which forces drop.
  assign exc_accept = fq_accept & fq_fifo_ready
                    & (fe_queue_msg_li == e_fe_exception);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_run;
    end else begin
      case (state_q)
        e_run:    if (exc_accept)         state_q <= e_parked;
        e_parked: if (cmd_nonattaboy_deq) state_q <= e_run;
        default:                          state_q <= e_run;
      endcase
    end
  end

  // All handshake/status outputs are held low while reset is asserted.
  assign fe_queue_ready_o   = ~reset_i & (fq_fifo_ready | drop);
  assign issue_pkt_v_o      = ~reset_i & fq_fifo_v;
  assign cmd_ready_o        = ~reset_i & cmd_fifo_ready;
  assign fe_cmd_v_o         = ~reset_i & cmd_fifo_v;
  assign fe_stalled_o       = ~reset_i & (state_q == e_parked);
  assign redirect_pending_o = ~reset_i & (pending_q != '0);

endmodule
